seq_dtc_param: RTL

//  Parametrised serial pattern detector; successor to the fixed 1101 detector.

---
 rtl/seq_dtc_param.sv | 92 +++++++++
 1 files changed

// File: rtl/seq_dtc_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Input bits are qualified by x_valid, and matches are counted in a saturating counter.
module seq_dtc_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(4'b1101),
  parameter int unsigned          DEF_LEN     = 4,
  parameter bit                   DEF_OVL     = 1'b1,
  localparam int unsigned         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic               w_cfg_ok;
  logic               w_cnt_max;

  // Match is judged on the history as it will be after this bit is shifted in.
  always_comb begin
    w_hist_shift = {r_hist[MAX_LEN-2:0], x};
    w_fill_inc   = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
    w_mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_match   = (w_fill_inc >= r_len) && (((w_hist_shift ^ r_pattern) & w_mask) == '0);
    w_cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    w_cnt_max = &r_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_ovl     <= DEF_OVL;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_z   <= 1'b0;
      r_err <= 1'b0;
      // A load, accepted or not, takes priority and swallows any coincident data bit.
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pattern <= cfg_pattern;
          r_len     <= cfg_len;
          r_ovl     <= cfg_ovl;
          r_hist    <= '0;
          r_fill    <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (x_valid) begin
        r_hist <= w_hist_shift;
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
        r_z    <= w_match;
        if (w_match && !w_cnt_max) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign z         = r_z;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_err;

endmodule
